// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the RV32I datapath and hazard_ctrl.
// master: datapath side (drives register ids, hazard/mem status; receives controls).
// slave:  hazard_ctrl side (receives status; drives forward/stall/flush/mem controls).
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM, RdW   register ids per stage
//   ResultSrcE0, PCSrcE, RegWriteM/W     load-in-E, branch taken, write enables
//   MemReqM, dmem_ready                  memory access in M, memory completion
//   ForwardAE/BE                         operand forward selects
//   StallF/D/E/M, FlushD/E/W             pipeline register controls
//   dmem_req, mem_err, stall_cnt         memory request, sticky timeout, stall count
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             dmem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, dmem_req, mem_err, stall_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, dmem_req, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard / pipeline controller for the 5-stage RV32I core.
// Forwarding selects, load-use stall, branch flush, and a small FSM that holds the
// whole pipeline while the instruction in M performs a data-memory access.
//   i_clk    clock, all state on posedge
//   i_rst_n  asynchronous active-low reset
//   io_bus   hazard_ctrl_if.slave bundle (see rtl/hazard_ctrl_if.sv)
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  hazard_ctrl_if.slave io_bus
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_mem_err, w_mem_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_memstall;
  logic             w_lw_stall;

  // M result beats W result for the same register; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    w_memstall     = 1'b0;
    case (r_state)
      StIdle: begin
        // dmem_ready is deliberately ignored here; a stale ready must not complete
        // an access that has not been requested yet.
        if (io_bus.MemReqM) begin
          w_memstall     = 1'b1;
          w_state_nxt    = StWait;
          w_wait_cnt_nxt = '0;
        end
      end
      StWait: begin
        w_memstall = 1'b1;
        if (io_bus.dmem_ready) begin
          w_state_nxt = StDone;
        end else if (r_wait_cnt == WaitLast) begin
          w_mem_err_nxt = 1'b1;
          w_state_nxt   = StDone;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      // The memory instruction moves to W at the end of this cycle.
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
      if (w_memstall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign w_lw_stall = io_bus.ResultSrcE0 && (io_bus.RdE != 5'd0) &&
                      ((io_bus.Rs1D == io_bus.RdE) || (io_bus.Rs2D == io_bus.RdE));

  always_comb begin
    io_bus.ForwardAE = fwd_sel(io_bus.Rs1E, io_bus.RdM, io_bus.RegWriteM,
                               io_bus.RdW, io_bus.RegWriteW);
    io_bus.ForwardBE = fwd_sel(io_bus.Rs2E, io_bus.RdM, io_bus.RegWriteM,
                               io_bus.RdW, io_bus.RegWriteW);
    io_bus.dmem_req  = w_memstall;
    io_bus.mem_err   = r_mem_err;
    io_bus.stall_cnt = r_stall_cnt;
    if (w_memstall) begin
      // Freeze everything; the branch in E is held and resolved after the access.
      io_bus.StallF = 1'b1;
      io_bus.StallD = 1'b1;
      io_bus.StallE = 1'b1;
      io_bus.StallM = 1'b1;
      io_bus.FlushD = 1'b0;
      io_bus.FlushE = 1'b0;
      io_bus.FlushW = 1'b1;
    end else begin
      // D register gives flush priority over stall when both are raised.
      io_bus.StallF = w_lw_stall;
      io_bus.StallD = w_lw_stall;
      io_bus.StallE = 1'b0;
      io_bus.StallM = 1'b0;
      io_bus.FlushD = io_bus.PCSrcE;
      io_bus.FlushE = w_lw_stall | io_bus.PCSrcE;
      io_bus.FlushW = 1'b0;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32I core.
- Drives stall, flush and forward selects for the F/D/E/M/W pipeline registers.
- Sequences multi-cycle data-memory accesses for the instruction in M using a req/ready handshake.
- Counts memory-stall cycles for performance reporting. Sits beside the pipeline registers in the top-level datapath.

Parameters:
TIMEOUT, 64, maximum WAIT cycles before an access is abandoned (min 2)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
Rs1D, Rs2D  input  5  source registers of the instruction in D
Rs1E, Rs2E, RdE  input  5  source and destination registers in E
ResultSrcE0  input  1  instruction in E is a load
PCSrcE  input  1  branch/jump taken in E
RdM, RdW  input  5  destination registers in M and W
RegWriteM, RegWriteW  input  1  write enables in M and W
MemReqM  input  1  instruction in M is a load or store
dmem_ready  input  1  data memory completes the access this cycle
ForwardAE, ForwardBE  output  2  operand forward select: 00 regfile, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM  output  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  output  1  load a bubble (all zeros) into D, E or W register
dmem_req  output  1  memory access request
mem_err  output  1  sticky timeout flag
stall_cnt  output  CNT_W  saturating count of memory-stall cycles

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, wait counter=0, mem_err=0, stall_cnt=0.
  - All combinational outputs follow from IDLE; with all inputs 0, every output is 0.
- Forwarding (combinational, shown for A; B identical using Rs2E):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00. M has priority over W.
- Memory FSM:
  - States: IDLE, WAIT, DONE.
  - IDLE: if MemReqM, dmem_req=1 and next state is WAIT; otherwise stay. dmem_ready is ignored in IDLE.
  - WAIT: dmem_req=1. If dmem_ready, next state is DONE. Else if wait counter==TIMEOUT-1, set mem_err=1 and next state is DONE. Else increment the counter.
  - The wait counter clears on entry to WAIT.
  - DONE: dmem_req=0 and next state is IDLE unconditionally. The memory instruction advances to W at the end of DONE, and the next M instruction is evaluated in the following IDLE cycle.
  - A zero-wait memory therefore costs 3 cycles per access: IDLE, WAIT, DONE.
- memstall = dmem_req (IDLE with MemReqM, or WAIT):
  - StallF, StallD, StallE and StallM are all 1.
  - FlushW=1.
  - FlushD=0 and FlushE=0 regardless of PCSrcE or load-use; the branch stays held in E and is acted on after the stall.
- When memstall=0:
  - Load-use hazard: lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
  - StallF=StallD=lwStall.
  - FlushE = lwStall | PCSrcE.
  - FlushD = PCSrcE.
  - StallE=StallM=0, FlushW=0.
  - If lwStall and PCSrcE occur together, FlushD=1, FlushE=1, StallF=1 and StallD=1. Flush wins in D because the D register gives flush priority.
- stall_cnt: increments each cycle memstall=1 and saturates at all-ones. It does not wrap.
- mem_err: set only by a timeout and cleared only by reset.
- Reset mid-access: the FSM returns to IDLE immediately and dmem_req drops asynchronously.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0, for exactly that cycle. RdE=0 -> no stall.
- Zero-wait memory: MemReqM=1, dmem_ready=1 from the WAIT cycle -> dmem_req high for 2 cycles, Stall{F,D,E,M}=1 and FlushW=1 for 2 cycles, DONE on the 3rd, stall_cnt=2.
- Wait states plus branch: 3 WAIT cycles before ready while PCSrcE=1 -> FlushD=FlushE=0 throughout the stall, then FlushD=FlushE=1 in DONE. stall_cnt=4.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> 4 WAIT cycles, mem_err=1 on entry to DONE, then IDLE. mem_err stays 1 across a later successful access.
- Reset mid-WAIT: drive reset=0 asynchronously -> dmem_req=0 and stalls=0 before the next clock edge. After release, state is IDLE, stall_cnt=0, mem_err=0.
